// File: rtl/serial_adder.sv
// Bit-serial N-bit adder: operands are captured on start, added LSB-first one bit per clock,
// and the sum is shifted into S from the MSB end. Optional overflow flag via SERIAL_ADDER_OVF_EN.
`timescale 1ns/1ps

module serial_adder #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         cin,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] S,
    output logic         cout
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic         ovf
`endif
);

    localparam int CW = (N > 2) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [N-1:0]   a_q, a_d;
    logic [N-1:0]   b_q, b_d;
    logic           c_q, c_d;
    logic [N-1:0]   s_q, s_d;
    logic           cout_q, cout_d;
    logic           done_q, done_d;
    logic           busy_q, busy_d;
    logic           sum_bit;
    logic           carry;
`ifdef SERIAL_ADDER_OVF_EN
    logic           ovf_q, ovf_d;
`endif

    assign sum_bit = a_q[0] ^ b_q[0] ^ c_q;
    assign carry   = (a_q[0] & b_q[0]) | (c_q & (a_q[0] ^ b_q[0]));

    always_comb begin
        // NOTE: every _d starts as its _q so no path through the case leaves one unassigned (no latches).
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        s_d     = s_q;
        cout_d  = cout_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
        ovf_d   = ovf_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = A;
                    b_d     = B;
                    c_d     = cin;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = ADD;
                end
            end
            ADD: begin
                s_d   = {sum_bit, s_q[N-1:1]};
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                c_d   = carry;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(N - 1)) begin
                    cout_d  = carry;
                    done_d  = 1'b1;
                    state_d = DONE;
`ifdef SERIAL_ADDER_OVF_EN
                    // c_q is the carry into the MSB while the last bit is processed.
                    ovf_d   = c_q ^ carry;
`endif
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= 1'b0;
            s_q     <= '0;
            cout_q  <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            s_q     <= s_d;
            cout_q  <= cout_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign S    = s_q;
    assign cout = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
    assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (N=4): directed vector table, multi-cycle corner
// sequences and an exhaustive sweep against a behavioural model.
`timescale 1ns/1ps

module tb_serial_adder;

    localparam int N = 4;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         cin;
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic         busy;
    logic         done;
    logic [N-1:0] S;
    logic         cout;
`ifdef SERIAL_ADDER_OVF_EN
    logic         ovf;
`endif

    int passed = 0;
    int total  = 0;

    serial_adder #(.N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .cin   (cin),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .done  (done),
        .S     (S),
        .cout  (cout)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic         ci;
        logic [N-1:0] s;
        logic         co;
        logic         ov;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        else
            passed++;
    endtask

    // One complete operation: accept, scramble inputs, wait for done, check result and the pulse width.
    task automatic run_op(input string tag, input logic [N-1:0] a, input logic [N-1:0] b,
                          input logic ci, input logic [N-1:0] es, input logic eco, input logic eov);
        int lat;
        lat = 0;
        @(negedge clk);
        A = a; B = b; cin = ci; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; A = ~a; B = ~b; cin = ~ci;
        for (int i = 1; i <= 3 * N && lat == 0; i++) begin
            @(posedge clk); #1;
            if (done) lat = i;
        end
        check({tag, " latency"}, lat, N);
        check({tag, " S"}, 32'(S), 32'(es));
        check({tag, " cout"}, 32'(cout), 32'(eco));
        check({tag, " busy_in_done"}, 32'(busy), 1);
`ifdef SERIAL_ADDER_OVF_EN
        check({tag, " ovf"}, 32'(ovf), 32'(eov));
`else
        if (eov === 1'bx) check({tag, " ovf_ref"}, 0, 1);
`endif
        @(posedge clk); #1;
        check({tag, " done_one_cycle"}, 32'(done), 0);
        check({tag, " idle_not_busy"}, 32'(busy), 0);
        check({tag, " S_held"}, 32'(S), 32'(es));
    endtask

    vec_t vecs[8];

    initial begin
        int n_done;
        int done_at;
        int last_done;
        logic [N:0] full;
        logic [N-1:0] sa, sb;
        logic eov;

        vecs[0] = '{4'b0101, 4'b0011, 1'b0, 4'b1000, 1'b0, 1'b1};
        vecs[1] = '{4'b1111, 4'b0001, 1'b0, 4'b0000, 1'b1, 1'b0};
        vecs[2] = '{4'b0000, 4'b0000, 1'b1, 4'b0001, 1'b0, 1'b0};
        vecs[3] = '{4'b0111, 4'b0001, 1'b0, 4'b1000, 1'b0, 1'b1};
        vecs[4] = '{4'b1000, 4'b1000, 1'b0, 4'b0000, 1'b1, 1'b1};
        vecs[5] = '{4'b1010, 4'b0101, 1'b1, 4'b0000, 1'b1, 1'b0};
        vecs[6] = '{4'b1111, 4'b1111, 1'b1, 4'b1111, 1'b1, 1'b0};
        vecs[7] = '{4'b0110, 4'b0011, 1'b1, 4'b1010, 1'b0, 1'b1};

        rst_n = 1'b0; start = 1'b0; cin = 1'b0; A = '0; B = '0;
        #12;
        check("reset S", 32'(S), 0);
        check("reset cout", 32'(cout), 0);
        check("reset busy", 32'(busy), 0);
        check("reset done", 32'(done), 0);
`ifdef SERIAL_ADDER_OVF_EN
        check("reset ovf", 32'(ovf), 0);
`endif
        @(negedge clk); rst_n = 1'b1;

        for (int i = 0; i < 8; i++)
            run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].ci,
                   vecs[i].s, vecs[i].co, vecs[i].ov);

        // start re-pulsed with 1111+1111 two cycles into ADD must be ignored
        n_done = 0; done_at = 0;
        @(negedge clk);
        A = 4'b0101; B = 4'b0011; cin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 1; i <= 3 * N; i++) begin
            @(posedge clk); #1;
            if (i == 2) begin A = 4'b1111; B = 4'b1111; start = 1'b1; end
            if (i == 3) start = 1'b0;
            if (done) begin n_done++; done_at = i; end
        end
        check("restart_ignored done_count", n_done, 1);
        check("restart_ignored latency", done_at, N);
        check("restart_ignored S", 32'(S), 32'b1000);
        check("restart_ignored cout", 32'(cout), 0);

        // reset mid-ADD abandons the operation
        @(negedge clk);
        A = 4'b0111; B = 4'b0111; cin = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); @(posedge clk); #3;
        check("midreset busy_before", 32'(busy), 1);
        rst_n = 1'b0;
        #1;
        check("midreset S", 32'(S), 0);
        check("midreset cout", 32'(cout), 0);
        check("midreset busy", 32'(busy), 0);
        check("midreset done", 32'(done), 0);
        @(negedge clk); rst_n = 1'b1;
        n_done = 0;
        for (int i = 0; i < 3 * N; i++) begin
            @(posedge clk); #1;
            if (done) n_done++;
        end
        check("midreset no_done", n_done, 0);
        run_op("after_reset", 4'b0101, 4'b0011, 1'b0, 4'b1000, 1'b0, 1'b1);

        // start held high: one result every N+2 cycles
        n_done = 0; last_done = -1;
        @(negedge clk);
        A = 4'b0110; B = 4'b0101; cin = 1'b0; start = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (done) begin
                n_done++;
                check($sformatf("held_start S@%0d", i), 32'(S), 32'b1011);
                if (last_done >= 0) check("held_start period", i - last_done, N + 2);
                else check("held_start first", i, N);
                last_done = i;
            end
        end
        start = 1'b0;
        check("held_start pulses", n_done, 3);
        repeat (2 * N) @(posedge clk);

        // exhaustive sweep against a behavioural model
        for (int v = 0; v < 512; v++) begin
            sa   = N'(v >> 5);
            sb   = N'(v >> 1);
            full = {1'b0, sa} + {1'b0, sb} + (N+1)'(v & 1);
            eov  = (sa[N-1] == sb[N-1]) && (full[N-1] != sa[N-1]);
            run_op($sformatf("ex a=%0h b=%0h c=%0d", sa, sb, v & 1), sa, sb, 1'(v & 1),
                   full[N-1:0], full[N], eov);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", passed, total);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 SHALL have parameter N, default 4, giving the operand and sum width in bits (N >= 2).
REQ-002 SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port start, input, 1 bit: request to add A and B, sampled only in IDLE.
REQ-005 SHALL have port cin, input, 1 bit: carry-in, captured with the operands.
REQ-006 SHALL have port A, input, N bits: first operand, captured on the accepting edge.
REQ-007 SHALL have port B, input, N bits: second operand, captured on the accepting edge.
REQ-008 SHALL have port busy, output, 1 bit: high while state is ADD or DONE.
REQ-009 SHALL have port done, output, 1 bit: one-cycle pulse marking the result as valid.
REQ-010 SHALL have port S, output, N bits: registered sum.
REQ-011 SHALL have port cout, output, 1 bit: registered carry-out of the MSB.
REQ-012 SHALL have port ovf, output, 1 bit: two's-complement overflow flag, present only per REQ-026.

Function
REQ-013 SHALL implement states IDLE, ADD and DONE, with a state register and a bit counter of ceil(log2(N)) bits or more.
REQ-014 In IDLE with start=1 at a rising edge: capture A and B into shift registers, load the carry register with cin, clear the counter, and go to ADD.
REQ-015 In ADD, each edge: compute sum bit = a0^b0^c and carry = a0&b0 | c&(a0^b0), shift the sum bit into S from the MSB end, shift the A and B registers right by one bit, and increment the counter.
REQ-016 SHALL leave ADD for DONE on the edge that processes bit N-1 (counter == N-1), registering cout at the same edge.
REQ-017 In DONE: done=1 for exactly one cycle, then unconditionally return to IDLE on the next edge.
REQ-018 Latency: if start is accepted at edge k, done SHALL be high during the cycle after edge k+N, and S/cout SHALL be final from edge k+N.
REQ-019 S and cout SHALL change only during ADD and SHALL hold their final values through DONE and IDLE until the next accepted start.
REQ-020 start SHALL be ignored in ADD and DONE, and changes on A, B or cin after capture SHALL have no effect.
REQ-021 If start is held high continuously, a new operation SHALL be accepted on the first edge in IDLE, giving one result per N+2 cycles.
REQ-022 The result SHALL equal (A + B + cin) mod 2^N, with cout = bit N of the full sum.

Reset
REQ-023 rst_n=0 SHALL immediately force state=IDLE and clear the counter, shift registers, carry register, S, cout, done, busy and ovf to 0, independent of clk.
REQ-024 A reset asserted mid-ADD SHALL abandon the operation, with no done pulse after release.
REQ-025 After rst_n deasserts, the first accepted start SHALL behave exactly as in REQ-014.

Configuration
REQ-026 With macro SERIAL_ADDER_OVF_EN defined, port ovf SHALL exist and SHALL be registered at the DONE-entry edge as carry-into-MSB XOR carry-out-of-MSB, held like S. Without the macro, port ovf and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-027 N=4, A=0101, B=0011, cin=0, start pulsed -> S=1000, cout=0, ovf=1 (if enabled), done high exactly 4 cycles after the accepting edge.
REQ-028 A=1111, B=0001, cin=0 -> S=0000, cout=1, ovf=0; A=0000, B=0000, cin=1 -> S=0001, cout=0.
REQ-029 start re-pulsed with A=1111, B=1111 two cycles into ADD -> ignored; the original sum completes with no extra done pulse.
REQ-030 rst_n driven low at ADD cycle 2 -> S, cout and busy read 0 immediately, and no done pulse follows.
REQ-031 start held high for 20 cycles with fixed operands -> done pulses every 6 cycles (N+2) with the same S each time.
REQ-032 Exhaustive check over all 512 combinations of A, B and cin at N=4 -> S, cout and ovf match the reference model on every done pulse.
